snake_engine: RTL

Game-state and pixel-colour stage that sits directly upstream of the VGA timing/output block in the snake design. It holds the snake body, direction, food and score. It advances the game once every MOVE_FRAMES frames. For every pixel coordinate supplied by the timing chain, it returns the 12-bit rbg colour with one-cycle latency.

---
 rtl/snake_pkg.sv | 51 +++++
 rtl/snake_lfsr.sv | 34 +++
 rtl/snake_engine.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : snake_pkg
//  Description : Shared constants for the snake game engine: grid geometry,
//                colours, direction/state encodings and reset positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package snake_pkg;

    // Grid geometry and game sizing
    localparam int GRID_W      = 40;
    localparam int GRID_H      = 30;
    localparam int CELL_SHIFT  = 4;
    localparam int MAX_LEN     = 16;
    localparam int INIT_LEN    = 3;
    localparam int MOVE_FRAMES = 8;

    // Register widths derived from the sizing above
    localparam int X_W   = 6;   // holds 0..GRID_W-1
    localparam int Y_W   = 5;   // holds 0..GRID_H-1
    localparam int LEN_W = 5;   // holds 0..MAX_LEN
    localparam int FC_W  = 3;   // holds 0..MOVE_FRAMES-1

    // Pixel colours, rbg order: [11:8] red, [7:4] blue, [3:0] green
    localparam logic [11:0] HEAD    = 12'hF0F;
    localparam logic [11:0] BODY    = 12'h00F;
    localparam logic [11:0] FOOD    = 12'hF00;
    localparam logic [11:0] BG_RUN  = 12'h000;
    localparam logic [11:0] BG_DEAD = 12'h400;

    // Direction encoding; a direction and its reverse differ only in bit 0
    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    // Game state encoding
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_DEAD = 1'b1;

    // Start positions
    localparam logic [X_W-1:0] HEAD_X0 = 6'd20;
    localparam logic [Y_W-1:0] HEAD_Y0 = 5'd15;
    localparam logic [X_W-1:0] FOOD_X0 = 6'd30;
    localparam logic [Y_W-1:0] FOOD_Y0 = 5'd15;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage
`default_nettype wire

// File: rtl/snake_lfsr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : snake_lfsr
//  Description : Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used
//                to place new food.
//  Revision    : 1.0 - initial release
// ============================================================================
module snake_lfsr
    import snake_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] value
);

    logic feedback;

    // Feedback from taps 16,14,13,11 (bits 15,13,12,10)
    always_comb begin
        feedback = value[15] ^ value[13] ^ value[12] ^ value[10];
    end

    // Shift every cycle; the seed is restored only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= LFSR_SEED;
        end else begin
            value <= {value[14:0], feedback};
        end
    end

endmodule
`default_nettype wire

// File: rtl/snake_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : snake_engine
//  Description : Snake game state (body, direction, food, score) and the
//                per-pixel colour lookup feeding the VGA output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module snake_engine
    import snake_pkg::*;
(
    input  logic        clk25,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        pixel_valid,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic [11:0] rbg,
    output logic        game_over,
    output logic [7:0]  score
);

    logic [X_W-1:0]   seg_x [MAX_LEN];
    logic [Y_W-1:0]   seg_y [MAX_LEN];
    logic [LEN_W-1:0] len;
    logic [1:0]       dir;
    logic [1:0]       pending_dir;
    logic [0:0]       state;
    logic [FC_W-1:0]  frame_cnt;
    logic [X_W-1:0]   food_x;
    logic [Y_W-1:0]   food_y;
    logic [15:0]      lfsr;

    logic             btn_any;
    logic [1:0]       btn_dir;
    logic [1:0]       step_dir;
    logic [X_W:0]     next_x_ext;
    logic [Y_W:0]     next_y_ext;
    logic [X_W-1:0]   next_x;
    logic [Y_W-1:0]   next_y;
    logic             collide;
    logic             eat;
    logic [X_W-1:0]   new_food_x;
    logic [Y_W-1:0]   new_food_y;
    logic             unused_lfsr_bits;

    snake_lfsr u_lfsr (
        .clk   (clk25),
        .rst_n (rst_n),
        .value (lfsr)
    );

    assign unused_lfsr_bits = ^{lfsr[15:13], lfsr[7:6]};

    // Button priority: up > down > left > right
    always_comb begin
        btn_any = btn_up | btn_down | btn_left | btn_right;
        if (btn_up)        btn_dir = DIR_UP;
        else if (btn_down) btn_dir = DIR_DOWN;
        else if (btn_left) btn_dir = DIR_LEFT;
        else               btn_dir = DIR_RIGHT;
    end

    // Candidate step: direction, next head, collisions, eating and new food
    always_comb begin
        // A reversal would run the head into the neck, so it is dropped
        step_dir   = (pending_dir == (dir ^ 2'd1)) ? dir : pending_dir;
        next_x_ext = {1'b0, seg_x[0]};
        next_y_ext = {1'b0, seg_y[0]};
        case (step_dir)
            DIR_RIGHT: next_x_ext = {1'b0, seg_x[0]} + 1'b1;
            DIR_LEFT:  next_x_ext = {1'b0, seg_x[0]} - 1'b1;
            DIR_UP:    next_y_ext = {1'b0, seg_y[0]} - 1'b1;
            default:   next_y_ext = {1'b0, seg_y[0]} + 1'b1;
        endcase
        next_x = next_x_ext[X_W-1:0];
        next_y = next_y_ext[Y_W-1:0];
        // Underflow wraps to a large value and is caught by the same bound
        collide = (next_x_ext >= (X_W+1)'(GRID_W)) || (next_y_ext >= (Y_W+1)'(GRID_H));
        // The tail cell is vacated by this step, so it is excluded
        for (int i = 0; i < MAX_LEN; i++) begin
            if (((LEN_W'(i) + LEN_W'(1)) < len) && (seg_x[i] == next_x) && (seg_y[i] == next_y)) begin
                collide = 1'b1;
            end
        end
        eat        = (next_x == food_x) && (next_y == food_y);
        new_food_x = (lfsr[5:0] >= X_W'(GRID_W)) ? lfsr[5:0] - X_W'(GRID_W) : lfsr[5:0];
        new_food_y = (lfsr[12:8] >= Y_W'(GRID_H)) ? lfsr[12:8] - Y_W'(GRID_H) : lfsr[12:8];
    end

    // Game state: buttons, frame pacing, stepping, death and restart
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= HEAD_X0 - X_W'(i);
                seg_y[i] <= HEAD_Y0;
            end
            len         <= LEN_W'(INIT_LEN);
            dir         <= DIR_RIGHT;
            pending_dir <= DIR_RIGHT;
            food_x      <= FOOD_X0;
            food_y      <= FOOD_Y0;
            frame_cnt   <= '0;
            state       <= ST_RUN;
            game_over   <= 1'b0;
            score       <= 8'd0;
        end else begin
            if (btn_any) begin
                pending_dir <= btn_dir;
            end
            if (state == ST_DEAD) begin
                frame_cnt <= '0;
                if (frame_start && btn_any) begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        seg_x[i] <= HEAD_X0 - X_W'(i);
                        seg_y[i] <= HEAD_Y0;
                    end
                    len         <= LEN_W'(INIT_LEN);
                    dir         <= DIR_RIGHT;
                    pending_dir <= DIR_RIGHT;
                    food_x      <= FOOD_X0;
                    food_y      <= FOOD_Y0;
                    state       <= ST_RUN;
                    game_over   <= 1'b0;
                    score       <= 8'd0;
                end
            end else if (frame_start) begin
                if (frame_cnt == FC_W'(MOVE_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    dir       <= step_dir;
                    if (collide) begin
                        state     <= ST_DEAD;
                        game_over <= 1'b1;
                    end else begin
                        for (int i = 0; i < MAX_LEN - 1; i++) begin
                            seg_x[i+1] <= seg_x[i];
                            seg_y[i+1] <= seg_y[i];
                        end
                        seg_x[0] <= next_x;
                        seg_y[0] <= next_y;
                        if (eat) begin
                            if (len < LEN_W'(MAX_LEN)) len <= len + 1'b1;
                            if (score != 8'hFF)        score <= score + 1'b1;
                            food_x <= new_food_x;
                            food_y <= new_food_y;
                        end
                    end
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    logic [9:0]  cell_x;
    logic [9:0]  cell_y;
    logic [11:0] colour;
    logic        hit_head;
    logic        hit_body;
    logic        hit_food;

    // Colour of the cell under the current pixel: head > body > food > bg
    always_comb begin
        cell_x   = pixel_x >> CELL_SHIFT;
        cell_y   = pixel_y >> CELL_SHIFT;
        hit_head = (cell_x == 10'(seg_x[0])) && (cell_y == 10'(seg_y[0]));
        hit_body = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((LEN_W'(i) < len) && (cell_x == 10'(seg_x[i])) && (cell_y == 10'(seg_y[i]))) begin
                hit_body = 1'b1;
            end
        end
        hit_food = (cell_x == 10'(food_x)) && (cell_y == 10'(food_y));
        if (hit_head)              colour = HEAD;
        else if (hit_body)         colour = BODY;
        else if (hit_food)         colour = FOOD;
        else if (state == ST_DEAD) colour = BG_DEAD;
        else                       colour = BG_RUN;
    end

    // Registered pixel output; blanked outside the visible area
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            rbg <= 12'h000;
        end else begin
            rbg <= pixel_valid ? colour : 12'h000;
        end
    end

endmodule
`default_nettype wire
